// File: rtl/micro_sequencer.sv
// Micro-step sequencer: drives the control-ROM step index, gates the datapath enable and evaluates conditional execution.
// Optional SEQ_EARLY_END_EN: an all-zero control word after step 0 ends the instruction early.
module micro_sequencer #(
    parameter int HALT_BIT = 0,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         instruction,
    input  logic [31:0]        control_lines,
    input  logic               flag_zero,
    input  logic               flag_carry,
    input  logic               flag_neg,
    input  logic               run_mode,
    input  logic               step_pulse,
    input  logic               resume_pulse,
    output logic [1:0]         micro_counter,
    output logic               flags_valid,
    output logic               cpu_en,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PAUSED,
        S_HALTED
    } state_t;

    state_t     state;
    logic [2:0] flag_snap;    // {neg, carry, zero}
    logic [2:0] eval_flags;
    logic       fetch;
    logic       early_end;
    logic       wrap;
    logic       unused_bits;

    assign fetch = (state == S_RUN) && (micro_counter == 2'd0);

`ifdef SEQ_EARLY_END_EN
    assign early_end = (micro_counter != 2'd0) && (control_lines == 32'd0);
`else
    assign early_end = 1'b0;
`endif

    assign wrap        = (micro_counter == 2'd3) || early_end;
    assign unused_bits = ^{instruction[4:0], control_lines};

    // The fetch step evaluates against the flags being captured this cycle.
    assign eval_flags = fetch ? {flag_neg, flag_carry, flag_zero} : flag_snap;

    always_comb begin
        flags_valid = 1'b0;
        case (instruction[7:5])
            3'b000:  flags_valid = 1'b1;
            3'b001:  flags_valid = eval_flags[0];
            3'b010:  flags_valid = ~eval_flags[0];
            3'b011:  flags_valid = eval_flags[1];
            3'b100:  flags_valid = ~eval_flags[1];
            3'b101:  flags_valid = eval_flags[2];
            3'b110:  flags_valid = ~eval_flags[2];
            default: flags_valid = 1'b0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= run_mode ? S_RUN : S_PAUSED;
            cpu_en        <= run_mode;
            halted        <= 1'b0;
            micro_counter <= 2'd0;
            flag_snap     <= 3'b000;
            instr_count   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (micro_counter == 2'd0)
                        flag_snap <= {flag_neg, flag_carry, flag_zero};
                    // HALT retires the instruction and wins over any wrap/step decision.
                    if (control_lines[HALT_BIT]) begin
                        micro_counter <= 2'd0;
                        instr_count   <= instr_count + COUNT_W'(1);
                        state         <= S_HALTED;
                        cpu_en        <= 1'b0;
                        halted        <= 1'b1;
                    end else if (wrap) begin
                        micro_counter <= 2'd0;
                        instr_count   <= instr_count + COUNT_W'(1);
                        if (!run_mode) begin
                            state  <= S_PAUSED;
                            cpu_en <= 1'b0;
                        end
                    end else begin
                        micro_counter <= micro_counter + 2'd1;
                    end
                end
                S_PAUSED: begin
                    micro_counter <= 2'd0;
                    if (step_pulse || run_mode) begin
                        state  <= S_RUN;
                        cpu_en <= 1'b1;
                    end
                end
                S_HALTED: begin
                    micro_counter <= 2'd0;
                    if (resume_pulse) begin
                        state  <= run_mode ? S_RUN : S_PAUSED;
                        cpu_en <= run_mode;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_PAUSED;
                    cpu_en        <= 1'b0;
                    halted        <= 1'b0;
                    micro_counter <= 2'd0;
                end
            endcase
        end
    end

endmodule
